// File: rtl/mem_bus_arbiter_pkg.sv
// Shared types and constants for the instruction/data memory arbiter.
// State codes, grant encoding and the all-lanes byte enable used for fetches.
package mem_bus_arbiter_pkg;

    typedef enum logic [1:0] {
        ARB_IDLE   = 2'd0,
        ARB_ACCESS = 2'd1,
        ARB_DONE   = 2'd2
    } arb_state_t;

    typedef enum logic {
        GNT_IF = 1'b0,
        GNT_D  = 1'b1
    } arb_gnt_t;

    localparam logic [3:0] BYTE_SEL_ALL    = 4'hF;
    localparam int         WAIT_STATES_MAX = 15;

endpackage

// File: rtl/mem_bus_arbiter_if.sv
// Bundle of the fetch port, data port, memory port and stall line.
// slave = arbiter view, master = CPU/memory environment view.
interface mem_bus_arbiter_if #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
);
    logic              if_req_i;
    logic [ADDR_W-1:0] if_addr_i;
    logic [DATA_W-1:0] if_data_o;
    logic              if_ack_o;

    logic              d_req_i;
    logic              d_we_i;
    logic [ADDR_W-1:0] d_addr_i;
    logic [3:0]        d_sel_i;
    logic [DATA_W-1:0] d_wdata_i;
    logic [DATA_W-1:0] d_rdata_o;
    logic              d_ack_o;

    logic              mem_ce_o;
    logic              mem_we_o;
    logic [ADDR_W-1:0] mem_addr_o;
    logic [3:0]        mem_sel_o;
    logic [DATA_W-1:0] mem_wdata_o;
    logic [DATA_W-1:0] mem_rdata_i;

    logic              stall_o;

    modport slave (
        input  if_req_i, if_addr_i,
        output if_data_o, if_ack_o,
        input  d_req_i, d_we_i, d_addr_i, d_sel_i, d_wdata_i,
        output d_rdata_o, d_ack_o,
        output mem_ce_o, mem_we_o, mem_addr_o, mem_sel_o, mem_wdata_o,
        input  mem_rdata_i,
        output stall_o
    );

    modport master (
        output if_req_i, if_addr_i,
        input  if_data_o, if_ack_o,
        output d_req_i, d_we_i, d_addr_i, d_sel_i, d_wdata_i,
        input  d_rdata_o, d_ack_o,
        input  mem_ce_o, mem_we_o, mem_addr_o, mem_sel_o, mem_wdata_o,
        output mem_rdata_i,
        input  stall_o
    );

endinterface

// File: rtl/mem_arb_pick.sv
// Combinational winner select between the fetch and data ports.
// MEM_ARB_RR_EN: on a tie the port not granted last wins; otherwise data
// always beats fetch and no last-grant input exists.
module mem_arb_pick
    import mem_bus_arbiter_pkg::*;
(
    input  logic     if_req,
    input  logic     d_req,
`ifdef MEM_ARB_RR_EN
    input  arb_gnt_t last_gnt,
`endif
    output arb_gnt_t gnt
);

    // A lone requester always wins; only a tie consults the policy.
    always_comb begin
        gnt = GNT_IF;
        if (if_req && d_req) begin
`ifdef MEM_ARB_RR_EN
            gnt = (last_gnt == GNT_IF) ? GNT_D : GNT_IF;
`else
            gnt = GNT_D;
`endif
        end else if (d_req) begin
            gnt = GNT_D;
        end
    end

endmodule

// File: rtl/mem_bus_arbiter.sv
// Shares one single-port memory between the instruction-fetch and data ports.
// Each access: IDLE (arbitrate) -> ACCESS for WAIT_STATES+1 cycles -> DONE (ack).
// Optional round-robin arbitration via MEM_ARB_RR_EN (see mem_arb_pick).
module mem_bus_arbiter
    import mem_bus_arbiter_pkg::*;
#(
    parameter int ADDR_W      = 32,
    parameter int DATA_W      = 32,
    parameter int WAIT_STATES = 1
) (
    input  logic clk,
    input  logic rst,
    mem_bus_arbiter_if.slave bus
);

    // The wait counter is 4 bits wide; larger settings cannot be represented.
    generate
        if (WAIT_STATES < 0 || WAIT_STATES > WAIT_STATES_MAX) begin : g_param_err
            $error("mem_bus_arbiter: WAIT_STATES must be within 0..15");
        end
    endgenerate

    localparam logic [3:0] CNT_INIT = 4'(WAIT_STATES);

    arb_state_t        state_reg, state_next;
    logic [3:0]        cnt_reg, cnt_next;
    arb_gnt_t          gnt_reg, gnt_next;
    arb_gnt_t          pick;

    logic              mem_ce_reg, mem_ce_next;
    logic              mem_we_reg, mem_we_next;
    logic [ADDR_W-1:0] mem_addr_reg, mem_addr_next;
    logic [3:0]        mem_sel_reg, mem_sel_next;
    logic [DATA_W-1:0] mem_wdata_reg, mem_wdata_next;

    logic              if_ack_reg, if_ack_next;
    logic              d_ack_reg, d_ack_next;
    logic [DATA_W-1:0] if_data_reg, if_data_next;
    logic [DATA_W-1:0] d_rdata_reg, d_rdata_next;

`ifdef MEM_ARB_RR_EN
    arb_gnt_t          last_gnt_reg, last_gnt_next;

    mem_arb_pick u_pick (
        .if_req   (bus.if_req_i),
        .d_req    (bus.d_req_i),
        .last_gnt (last_gnt_reg),
        .gnt      (pick)
    );
`else
    mem_arb_pick u_pick (
        .if_req (bus.if_req_i),
        .d_req  (bus.d_req_i),
        .gnt    (pick)
    );
`endif

    // Next-state and next-output logic for the IDLE/ACCESS/DONE sequence.
    always_comb begin
        state_next     = state_reg;
        cnt_next       = cnt_reg;
        gnt_next       = gnt_reg;
        mem_ce_next    = mem_ce_reg;
        mem_we_next    = mem_we_reg;
        mem_addr_next  = mem_addr_reg;
        mem_sel_next   = mem_sel_reg;
        mem_wdata_next = mem_wdata_reg;
        if_ack_next    = 1'b0;
        d_ack_next     = 1'b0;
        if_data_next   = if_data_reg;
        d_rdata_next   = d_rdata_reg;
`ifdef MEM_ARB_RR_EN
        last_gnt_next  = last_gnt_reg;
`endif
        case (state_reg)
            ARB_IDLE: begin
                if (bus.if_req_i || bus.d_req_i) begin
                    state_next  = ARB_ACCESS;
                    gnt_next    = pick;
                    mem_ce_next = 1'b1;
                    cnt_next    = CNT_INIT;
`ifdef MEM_ARB_RR_EN
                    last_gnt_next = pick;
`endif
                    if (pick == GNT_D) begin
                        mem_we_next    = bus.d_we_i;
                        mem_addr_next  = bus.d_addr_i;
                        mem_sel_next   = bus.d_sel_i;
                        mem_wdata_next = bus.d_wdata_i;
                    end else begin
                        // Fetches are always full-word reads.
                        mem_we_next    = 1'b0;
                        mem_addr_next  = bus.if_addr_i;
                        mem_sel_next   = BYTE_SEL_ALL;
                        mem_wdata_next = '0;
                    end
                end
            end
            ARB_ACCESS: begin
                if (cnt_reg != 4'd0) begin
                    cnt_next = cnt_reg - 4'd1;
                end else begin
                    // Last memory cycle: capture read data and release the memory.
                    state_next  = ARB_DONE;
                    mem_ce_next = 1'b0;
                    mem_we_next = 1'b0;
                    if (gnt_reg == GNT_IF) begin
                        if_data_next = bus.mem_rdata_i;
                        if_ack_next  = 1'b1;
                    end else begin
                        if (!mem_we_reg) begin
                            d_rdata_next = bus.mem_rdata_i;
                        end
                        d_ack_next = 1'b1;
                    end
                end
            end
            ARB_DONE: begin
                // Ack is high this cycle; new arbitration happens in the following IDLE.
                state_next = ARB_IDLE;
            end
            default: begin
                state_next = ARB_IDLE;
            end
        endcase
    end

    // State and registered-output update; reset aborts any access immediately.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_reg     <= ARB_IDLE;
            cnt_reg       <= 4'd0;
            gnt_reg       <= GNT_IF;
            mem_ce_reg    <= 1'b0;
            mem_we_reg    <= 1'b0;
            mem_addr_reg  <= '0;
            mem_sel_reg   <= 4'd0;
            mem_wdata_reg <= '0;
            if_ack_reg    <= 1'b0;
            d_ack_reg     <= 1'b0;
            if_data_reg   <= '0;
            d_rdata_reg   <= '0;
`ifdef MEM_ARB_RR_EN
            last_gnt_reg  <= GNT_IF;
`endif
        end else begin
            state_reg     <= state_next;
            cnt_reg       <= cnt_next;
            gnt_reg       <= gnt_next;
            mem_ce_reg    <= mem_ce_next;
            mem_we_reg    <= mem_we_next;
            mem_addr_reg  <= mem_addr_next;
            mem_sel_reg   <= mem_sel_next;
            mem_wdata_reg <= mem_wdata_next;
            if_ack_reg    <= if_ack_next;
            d_ack_reg     <= d_ack_next;
            if_data_reg   <= if_data_next;
            d_rdata_reg   <= d_rdata_next;
`ifdef MEM_ARB_RR_EN
            last_gnt_reg  <= last_gnt_next;
`endif
        end
    end

    assign bus.mem_ce_o    = mem_ce_reg;
    assign bus.mem_we_o    = mem_we_reg;
    assign bus.mem_addr_o  = mem_addr_reg;
    assign bus.mem_sel_o   = mem_sel_reg;
    assign bus.mem_wdata_o = mem_wdata_reg;
    assign bus.if_ack_o    = if_ack_reg;
    assign bus.d_ack_o     = d_ack_reg;
    assign bus.if_data_o   = if_data_reg;
    assign bus.d_rdata_o   = d_rdata_reg;

    // Pipeline freeze: any request that is not completing this cycle.
    assign bus.stall_o = (bus.if_req_i & ~if_ack_reg) | (bus.d_req_i & ~d_ack_reg);

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// Bench for mem_bus_arbiter: directed transactions on a WAIT_STATES=1 instance
// checked every cycle against a timeline model, plus a WAIT_STATES=0 instance
// for back-to-back fetch timing. Honors MEM_ARB_RR_EN in the model.
module tb_mem_bus_arbiter;

    localparam int WS = 1;

    logic clk;
    logic rst;

    int checks = 0;
    int errors = 0;

    mem_bus_arbiter_if #(.ADDR_W(32), .DATA_W(32)) bus ();
    mem_bus_arbiter_if #(.ADDR_W(32), .DATA_W(32)) bus0 ();

    mem_bus_arbiter #(.ADDR_W(32), .DATA_W(32), .WAIT_STATES(WS)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    mem_bus_arbiter #(.ADDR_W(32), .DATA_W(32), .WAIT_STATES(0)) dut0 (
        .clk (clk),
        .rst (rst),
        .bus (bus0)
    );

    // Memory contents: a fixed pattern, word 0 holds 0x34011100.
    function automatic logic [31:0] rom(input logic [31:0] a);
        return 32'h34011100 ^ a;
    endfunction

    assign bus.mem_rdata_i  = rom(bus.mem_addr_o);
    assign bus0.mem_rdata_i = rom(bus0.mem_addr_o);

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic void check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endfunction

    // ---------------- timeline model of the WS=1 instance ----------------
    int          mc;
    int          m_start;
    int          m_free;
    bit          m_busy;
    bit          m_win_d;
    bit          m_we;
    logic [31:0] m_addr;
    logic [31:0] m_wdata;
    logic [3:0]  m_sel;
    logic [31:0] exp_if_data;
    logic [31:0] exp_d_rdata;
`ifdef MEM_ARB_RR_EN
    bit          m_last_d;
`endif

    initial begin
        bit in_acc;
        bit e_if;
        bit e_d;
        bit stall_e;
        forever begin
            @(negedge clk);
            if (!rst) begin
                mc = 0; m_busy = 1'b0; m_free = 0;
                exp_if_data = '0; exp_d_rdata = '0;
`ifdef MEM_ARB_RR_EN
                m_last_d = 1'b0;
`endif
                check("rst mem_ce", 32'(bus.mem_ce_o), 32'd0);
                check("rst mem_we", 32'(bus.mem_we_o), 32'd0);
                check("rst if_ack", 32'(bus.if_ack_o), 32'd0);
                check("rst d_ack", 32'(bus.d_ack_o), 32'd0);
                check("rst if_data", bus.if_data_o, 32'd0);
                check("rst d_rdata", bus.d_rdata_o, 32'd0);
            end else begin
                in_acc = m_busy && (mc >= m_start + 1) && (mc <= m_start + WS + 1);
                e_if = 1'b0;
                e_d  = 1'b0;
                if (m_busy && mc == m_start + WS + 2) begin
                    if (!m_win_d) begin
                        e_if = 1'b1;
                        exp_if_data = rom(m_addr);
                    end else begin
                        e_d = 1'b1;
                        if (!m_we) exp_d_rdata = rom(m_addr);
                    end
                    m_busy = 1'b0;
                    m_free = mc + 1;
                end
                stall_e = (bus.if_req_i && !e_if) || (bus.d_req_i && !e_d);
                check("mem_ce", 32'(bus.mem_ce_o), 32'(in_acc));
                check("mem_we", 32'(bus.mem_we_o), 32'(in_acc && m_we));
                check("if_ack", 32'(bus.if_ack_o), 32'(e_if));
                check("d_ack", 32'(bus.d_ack_o), 32'(e_d));
                check("if_data", bus.if_data_o, exp_if_data);
                check("d_rdata", bus.d_rdata_o, exp_d_rdata);
                check("stall", 32'(bus.stall_o), 32'(stall_e));
                if (in_acc) begin
                    check("mem_addr", bus.mem_addr_o, m_addr);
                    check("mem_sel", 32'(bus.mem_sel_o), 32'(m_sel));
                    if (m_we) check("mem_wdata", bus.mem_wdata_o, m_wdata);
                end
                if (!m_busy && mc >= m_free && (bus.if_req_i || bus.d_req_i)) begin
`ifdef MEM_ARB_RR_EN
                    m_win_d  = bus.d_req_i && (!bus.if_req_i || !m_last_d);
                    m_last_d = m_win_d;
`else
                    m_win_d  = bus.d_req_i;
`endif
                    m_busy  = 1'b1;
                    m_start = mc;
                    if (m_win_d) begin
                        m_we = bus.d_we_i; m_addr = bus.d_addr_i;
                        m_sel = bus.d_sel_i; m_wdata = bus.d_wdata_i;
                    end else begin
                        m_we = 1'b0; m_addr = bus.if_addr_i;
                        m_sel = 4'hF; m_wdata = '0;
                    end
                end
                mc++;
            end
        end
    end

    // ---------------- stimulus ----------------
    // Raise requests in the current cycle (cycle 0), drop each on its ack,
    // optionally drop all early; report ack cycles (-1 if none).
    task automatic run_txn(input bit do_if, input logic [31:0] ia,
                           input bit do_d, input bit dwe, input logic [31:0] da,
                           input logic [3:0] ds, input logic [31:0] dwd,
                           input int drop_after, input string tag,
                           output int if_cyc, output int d_cyc);
        bit if_pend;
        bit d_pend;
        int k;
        if_cyc = -1; d_cyc = -1;
        bus.if_req_i = do_if; bus.if_addr_i = ia;
        bus.d_req_i = do_d; bus.d_we_i = dwe; bus.d_addr_i = da;
        bus.d_sel_i = ds; bus.d_wdata_i = dwd;
        if_pend = do_if; d_pend = do_d; k = 0;
        while ((if_pend || d_pend) && k < 40) begin
            @(posedge clk); #1; k++;
            if (drop_after > 0 && k == drop_after) begin
                bus.if_req_i = 1'b0; bus.d_req_i = 1'b0;
            end
            if (if_pend && bus.if_ack_o) begin if_pend = 1'b0; if_cyc = k; bus.if_req_i = 1'b0; end
            if (d_pend && bus.d_ack_o)   begin d_pend = 1'b0;  d_cyc = k;  bus.d_req_i = 1'b0; end
        end
        check({tag, " ack timeout"}, 32'(if_pend || d_pend), 32'd0);
        $display("txn %s: if_ack@%0d d_ack@%0d if_data=%h d_rdata=%h",
                 tag, if_cyc, d_cyc, bus.if_data_o, bus.d_rdata_o);
        @(posedge clk); #1;
    endtask

    initial begin
        int ic;
        int dc;
        int a1;
        int a2;
        int k;
        logic [31:0] v1;
        logic [31:0] v2;
        rst = 1'b0;
        bus.if_req_i = 0; bus.if_addr_i = 0; bus.d_req_i = 0; bus.d_we_i = 0;
        bus.d_addr_i = 0; bus.d_sel_i = 0; bus.d_wdata_i = 0;
        bus0.if_req_i = 0; bus0.if_addr_i = 0; bus0.d_req_i = 0; bus0.d_we_i = 0;
        bus0.d_addr_i = 0; bus0.d_sel_i = 0; bus0.d_wdata_i = 0;
        repeat (3) @(posedge clk);
        #1 rst = 1'b1;
        @(posedge clk); #1;

        // Fetch from 0x0: ack in cycle 3 with the stored instruction.
        run_txn(1, 32'h0, 0, 0, 32'h0, 4'h0, 32'h0, 0, "fetch0", ic, dc);
        check("fetch0 ack cycle", 32'(ic), 32'd3);
        check("fetch0 data", bus.if_data_o, 32'h34011100);

        // Data read from 0x20.
        run_txn(0, 32'h0, 1, 0, 32'h20, 4'hF, 32'h0, 0, "read20", ic, dc);
        check("read20 ack cycle", 32'(dc), 32'd3);
        check("read20 data", bus.d_rdata_o, 32'h34011120);

        // Data write: read data must keep the previous read value.
        run_txn(0, 32'h0, 1, 1, 32'h10, 4'b0011, 32'hDEADBEEF, 0, "write10", ic, dc);
        check("write10 ack cycle", 32'(dc), 32'd3);
        check("write10 rdata held", bus.d_rdata_o, 32'h34011120);

        // Simultaneous requests; last grant was data.
        run_txn(1, 32'h40, 1, 0, 32'h44, 4'hF, 32'h0, 0, "tie1", ic, dc);
`ifdef MEM_ARB_RR_EN
        check("tie1 if ack cycle", 32'(ic), 32'd3);
        check("tie1 d ack cycle", 32'(dc), 32'd7);
`else
        check("tie1 d ack cycle", 32'(dc), 32'd3);
        check("tie1 if ack cycle", 32'(ic), 32'd7);
`endif
        check("tie1 if data", bus.if_data_o, 32'h34011140);
        check("tie1 d data", bus.d_rdata_o, 32'h34011144);

        // Request withdrawn after one cycle: access still completes and acks.
        run_txn(0, 32'h0, 1, 0, 32'h48, 4'hF, 32'h0, 1, "drop48", ic, dc);
        check("drop48 ack cycle", 32'(dc), 32'd3);
        check("drop48 data", bus.d_rdata_o, 32'h34011148);

        // Second tie with a write.
        run_txn(1, 32'h50, 1, 1, 32'h54, 4'hC, 32'h12345678, 0, "tie2", ic, dc);
        check("tie2 if data", bus.if_data_o, 32'h34011150);

        // Reset during ACCESS, request held across it.
        bus.if_req_i = 1'b1; bus.if_addr_i = 32'h8;
        @(posedge clk); #1;
        @(posedge clk); #1;
        check("rstmid ce before", 32'(bus.mem_ce_o), 32'd1);
        rst = 1'b0; #1;
        check("rstmid ce", 32'(bus.mem_ce_o), 32'd0);
        check("rstmid if_ack", 32'(bus.if_ack_o), 32'd0);
        check("rstmid d_ack", 32'(bus.d_ack_o), 32'd0);
        @(posedge clk); #1;
        @(posedge clk); #1;
        rst = 1'b1;
        ic = -1; k = 0;
        while (ic < 0 && k < 40) begin
            @(posedge clk); #1; k++;
            if (bus.if_ack_o) begin ic = k; bus.if_req_i = 1'b0; end
        end
        $display("txn rstmid: if_ack@%0d if_data=%h", ic, bus.if_data_o);
        check("rstmid restart ack cycle", 32'(ic), 32'd3);
        check("rstmid data", bus.if_data_o, 32'h34011108);
        @(posedge clk); #1;

        // WAIT_STATES=0 instance: back-to-back fetches 0x0 then 0x4.
        bus0.if_req_i = 1'b1; bus0.if_addr_i = 32'h0;
        a1 = -1; a2 = -1; v1 = '0; v2 = '0;
        for (int c = 1; c <= 10; c++) begin
            @(posedge clk); #1;
            if (bus0.if_ack_o) begin
                if (a1 < 0) begin
                    a1 = c; v1 = bus0.if_data_o; bus0.if_addr_i = 32'h4;
                end else if (a2 < 0) begin
                    a2 = c; v2 = bus0.if_data_o; bus0.if_req_i = 1'b0;
                end
            end
        end
        $display("txn ws0 pair: acks@%0d,%0d data=%h,%h", a1, a2, v1, v2);
        check("ws0 first ack cycle", 32'(a1), 32'd2);
        check("ws0 second ack cycle", 32'(a2), 32'd5);
        check("ws0 first data", v1, 32'h34011100);
        check("ws0 second data", v2, 32'h34011104);

        repeat (2) @(posedge clk);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
